// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. Requester 0 is the
//   pipeline EXE stage, requester 1 a secondary client (address generation or
//   debug). Arbitration is round-robin. Each operation takes three phases:
//   IDLE (accept) -> EXEC (drive the ALU for one cycle) -> RESP (hold the
//   registered result until the owning requester consumes it).
//
// Ports
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   rX_valid / rX_ready     : request handshake (ready is combinational, IDLE only)
//   rX_a, rX_b, rX_imm      : operands, sampled only at accept
//   rX_signals              : [2] source select (1 = imm), [1:0] ALU op
//   rX_rsp_valid/_ready     : response handshake for the owning requester
//   rsp_result              : registered ALU result, qualified by rX_rsp_valid
//   alu_a, alu_b, alu_op    : shared ALU inputs (latched operands)
//   alu_result              : shared ALU combinational output
//   busy                    : high whenever the state is not IDLE
//
// Optional feature (macro ALU_ARB_STATS_EN)
//   Adds grant_cnt0 / grant_cnt1: saturating 16-bit accept counters.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [WIDTH-1:0] r0_imm,
  input  logic [2:0]       r0_signals,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [WIDTH-1:0] r1_imm,
  input  logic [2:0]       r1_signals,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic             r_busy;
  logic             r_rsp_valid0;
  logic             r_rsp_valid1;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_op_code;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      r_grant_cnt0;
  logic [15:0]      r_grant_cnt1;
`endif

  logic             w_any_valid;
  logic             w_winner;
  logic             w_owner_rsp_ready;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [1:0]       w_sel_op;

  // Round-robin winner: on a tie the requester that was not granted last wins.
  always_comb begin
    w_any_valid = r0_valid | r1_valid;
    if (r0_valid && r1_valid) begin
      w_winner = ~r_last_grant;
    end else if (r1_valid) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
  end

  // Operand selection for the winner, including the B/immediate source mux.
  always_comb begin
    if (w_winner) begin
      w_sel_a  = r1_a;
      w_sel_b  = r1_signals[2] ? r1_imm : r1_b;
      w_sel_op = r1_signals[1:0];
    end else begin
      w_sel_a  = r0_a;
      w_sel_b  = r0_signals[2] ? r0_imm : r0_b;
      w_sel_op = r0_signals[1:0];
    end
  end

  // Request-ready is combinational and only for the winner in IDLE; it is
  // forced low while reset is held so no handshake completes during reset.
  always_comb begin
    if (!reset && (r_state == S_IDLE)) begin
      r0_ready = r0_valid & ~w_winner;
      r1_ready = r1_valid & w_winner;
    end else begin
      r0_ready = 1'b0;
      r1_ready = 1'b0;
    end
    w_owner_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;
  end

  // Arbitration FSM with registered datapath and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_op_a       <= {WIDTH{1'b0}};
      r_op_b       <= {WIDTH{1'b0}};
      r_op_code    <= 2'b00;
      r_result     <= {WIDTH{1'b0}};
`ifdef ALU_ARB_STATS_EN
      r_grant_cnt0 <= 16'd0;
      r_grant_cnt1 <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_op_a    <= w_sel_a;
            r_op_b    <= w_sel_b;
            r_op_code <= w_sel_op;
            r_owner   <= w_winner;
            r_busy    <= 1'b1;
            r_state   <= S_EXEC;
`ifdef ALU_ARB_STATS_EN
            if (!w_winner && (r_grant_cnt0 != 16'hFFFF)) begin
              r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            end
            if (w_winner && (r_grant_cnt1 != 16'hFFFF)) begin
              r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            end
`endif
          end
        end
        S_EXEC: begin
          r_result     <= alu_result;
          r_rsp_valid0 <= ~r_owner;
          r_rsp_valid1 <= r_owner;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's rsp_ready can release the response.
          if (w_owner_rsp_ready) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_busy       <= 1'b0;
            r_last_grant <= r_owner;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid0 <= 1'b0;
          r_rsp_valid1 <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a        = r_op_a;
  assign alu_b        = r_op_b;
  assign alu_op       = r_op_code;
  assign rsp_result   = r_result;
  assign r0_rsp_valid = r_rsp_valid0;
  assign r1_rsp_valid = r_rsp_valid1;
  assign busy         = r_busy;
`ifdef ALU_ARB_STATS_EN
  assign grant_cnt0   = r_grant_cnt0;
  assign grant_cnt1   = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Scoreboard bench. Stimulus queues feed a per-requester driver; a
//   transaction-level model predicts grants, handshake timing and results;
//   a separate monitor pops expected responses when the DUT presents them.
//   The shared ALU is modelled in the bench; op 11 is given XOR behaviour.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic [2:0]   sig;
    logic [W-1:0] exp;
  } op_t;

  typedef struct packed {
    logic         owner;
    logic [W-1:0] res;
  } sb_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
  logic         r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
  logic [W-1:0] r0_a, r0_b, r0_imm, r1_a, r1_b, r1_imm;
  logic [2:0]   r0_signals, r1_signals;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;
  logic         busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  op_t q0[$];
  op_t q1[$];
  sb_t sb[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  rr0 = 1'b1, rr1 = 1'b1, rand_rsp = 1'b0;

  // model state (written only by the model process)
  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  bit           m_owner = 1'b0;
  int           m_age = 0;
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_op;
  int           m_cnt0 = 0, m_cnt1 = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_op);

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_imm(r0_imm),
    .r0_signals(r0_signals), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_imm(r1_imm),
    .r1_signals(r1_signals), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .rsp_result(rsp_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_dir(input int req, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [2:0] sig,
                          input logic [W-1:0] exp);
    op_t op;
    op = '{a: a, b: b, imm: imm, sig: sig, exp: exp};
    if (req == 0) q0.push_back(op);
    else          q1.push_back(op);
  endtask

  task automatic push_rand(input int req);
    logic [W-1:0] a, b, imm;
    logic [2:0]   sig;
    a   = W'($urandom);
    b   = W'($urandom);
    imm = W'($urandom);
    sig = 3'($urandom);
    push_dir(req, a, b, imm, sig, ref_alu(a, sig[2] ? imm : b, sig[1:0]));
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !m_busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!done) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // Driver: presents the head of each request queue, holding it until accepted.
  initial begin : driver
    bit acc0, acc1;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_imm = '0; r0_signals = 3'b000;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_imm = '0; r1_signals = 3'b000;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc0 = r0_valid && r0_ready;
      acc1 = r1_valid && r1_ready;
      @(posedge clk);
      #1;
      if (acc0 && q0.size() > 0) q0.delete(0);
      if (acc1 && q1.size() > 0) q1.delete(0);
      if (q0.size() > 0) begin
        r0_valid = 1'b1; r0_a = q0[0].a; r0_b = q0[0].b; r0_imm = q0[0].imm; r0_signals = q0[0].sig;
      end else begin
        r0_valid = 1'b0; r0_a = W'($urandom); r0_b = W'($urandom); r0_imm = W'($urandom);
        r0_signals = 3'($urandom);
      end
      if (q1.size() > 0) begin
        r1_valid = 1'b1; r1_a = q1[0].a; r1_b = q1[0].b; r1_imm = q1[0].imm; r1_signals = q1[0].sig;
      end else begin
        r1_valid = 1'b0; r1_a = W'($urandom); r1_b = W'($urandom); r1_imm = W'($urandom);
        r1_signals = 3'($urandom);
      end
      r0_rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : rr0;
      r1_rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : rr1;
    end
  end

  // Model: one operation in flight; accept at N, response from N+2, next
  // accept only after the owner takes the response; ties alternate.
  initial begin : model
    int  win;
    op_t op;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_outputs",
            {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, busy, rsp_result, alu_a, alu_b, alu_op},
            64'd0);
        m_busy = 1'b0; m_last = 1'b1; m_age = 0;
        m_cnt0 = 0; m_cnt1 = 0;
        sb.delete();
      end else begin
        win = -1;
        if (!m_busy) begin
          if (r0_valid && r1_valid) win = m_last ? 0 : 1;
          else if (r0_valid)        win = 0;
          else if (r1_valid)        win = 1;
        end
        chk("r0_ready", r0_ready, (win == 0));
        chk("r1_ready", r1_ready, (win == 1));
        chk("busy", busy, m_busy);
        chk("r0_rsp_valid", r0_rsp_valid, m_busy && m_age >= 2 && !m_owner);
        chk("r1_rsp_valid", r1_rsp_valid, m_busy && m_age >= 2 && m_owner);
        if (m_busy && m_age == 1) chk("alu_inputs", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
        if (!m_busy) begin
          if (win >= 0) begin
            op = (win == 0) ? q0[0] : q1[0];
            m_a     = (win == 0) ? r0_a : r1_a;
            m_b     = (win == 0) ? (r0_signals[2] ? r0_imm : r0_b) : (r1_signals[2] ? r1_imm : r1_b);
            m_op    = (win == 0) ? r0_signals[1:0] : r1_signals[1:0];
            m_owner = (win == 1);
            m_busy  = 1'b1;
            m_age   = 1;
            if (win == 0) m_cnt0++;
            else          m_cnt1++;
            sb.push_back('{owner: (win == 1), res: op.exp});
          end
        end else if (m_age >= 2 && (m_owner ? r1_rsp_ready : r0_rsp_ready)) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end else begin
          m_age++;
        end
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && (r0_rsp_valid || r1_rsp_valid)) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          chk("rsp_owner", r1_rsp_valid, sb[0].owner);
          chk("rsp_result", rsp_result, sb[0].res);
          if (r1_rsp_valid ? r1_rsp_ready : r0_rsp_ready) sb.delete(0);
        end
      end
    end
  end

  initial begin : main
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // directed ALU ops, r0 via B and r1 via immediate
    push_dir(0, 16'd15, 16'hFFF6, 16'd5, 3'b000, 16'h0006);
    push_dir(0, 16'd15, 16'hFFF6, 16'd5, 3'b001, 16'h0005);
    push_dir(0, 16'd15, 16'hFFF6, 16'd5, 3'b010, 16'h0019);
    wait_drain(50);
    push_dir(1, 16'd15, 16'hFFF6, 16'd5, 3'b101, 16'd20);
    push_dir(1, 16'd15, 16'hFFF6, 16'd5, 3'b110, 16'd10);
    push_dir(1, 16'd15, 16'hFFF6, 16'd5, 3'b100, 16'd5);
    wait_drain(50);

    // fairness: both continuously valid
    for (int i = 0; i < 4; i++) begin
      push_rand(0);
      push_rand(1);
    end
    wait_drain(60);

    // response backpressure on r0 while r1 waits
    rr0 = 1'b0;
    push_rand(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0_rsp_valid) break;
    end
    push_rand(1);
    repeat (5) @(posedge clk);
    #2 rr0 = 1'b1;
    wait_drain(40);

    // reset while r0 owns an operation in EXEC
    push_rand(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0_ready) break;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    push_rand(0);
    push_rand(1);
    wait_drain(40);

    // randomized traffic with random response backpressure
    rand_rsp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1 && q0.size() < 2) push_rand(0);
      if ($urandom_range(0, 1) == 1 && q1.size() < 2) push_rand(1);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #2;
    end
    rand_rsp = 1'b0;
    wait_drain(400);

`ifdef ALU_ARB_STATS_EN
    // counters restart at the last reset; compare against the model's counts
    chk("grant_cnt0", grant_cnt0, m_cnt0);
    chk("grant_cnt1", grant_cnt1, m_cnt1);
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) push_rand(0);
    for (int i = 0; i < 2; i++) push_rand(1);
    wait_drain(60);
    chk("grant_cnt0_3", grant_cnt0, 64'd3);
    chk("grant_cnt1_2", grant_cnt1, 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
